// File: rtl/bus_pkg.sv
// Shared bus definitions: one-hot target FSM states and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int BUS_ADDR_W = 8;   // system address bus width
  localparam int BUS_DATA_W = 32;  // memory word width
  localparam int WAIT_CNT_W = 4;   // wait-state counter, holds 0..15

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ADDR = 4'b0010,
    WAIT = 4'b0100,
    COMP = 4'b1000
  } bus_state_t;

endpackage

// File: rtl/bus_tgt_mem.sv
// Word array behind the bus target: synchronous write, combinational read.
// Latency: write lands on the clock edge with we=1; rdata follows addr in the same cycle.
// Backpressure: none, one access per cycle; contents are not reset.
//
// Ports: clk, we (write enable), addr (word address), wdata (write word),
//        rdata (word currently stored at addr).
// The target registers rdata into data_read on the same edge that commits a write,
// so both kinds of access complete on the edge the FSM enters COMP.
module bus_tgt_mem #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int WORDS = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_target.sv
// Bus slave: latches address on ale_en, takes one read/write strobe, inserts WAIT_CYCLES wait states.
// Latency: bus_ready (with valid data_read) WAIT_CYCLES+1 cycles after the edge that sampled the strobe.
// Backpressure: none; strobes outside ADDR are dropped, bus_busy flags an open transfer.
//
// Ports: clk, rst (async, active high); ale_en/addr_in (address phase);
//        bus_read_en/bus_write_en/data_write (strobe phase); data_read (registered read word);
//        bus_ready (1-cycle completion pulse); bus_busy (ADDR/WAIT/COMP); bus_err (range error pulse).
// Optional macro BUS_TGT_RANGE_CHK_EN: only DEPTH words exist; out-of-range accesses
// complete normally, touch no memory, read back 0 and raise bus_err with bus_ready.
module bus_mem_target
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_W,
  parameter int DATA_WIDTH  = BUS_DATA_W,
  parameter int DEPTH       = 192,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ale_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  bus_read_en,
  input  logic                  bus_write_en,
  input  logic [DATA_WIDTH-1:0] data_write,
  output logic [DATA_WIDTH-1:0] data_read,
  output logic                  bus_ready,
  output logic                  bus_busy,
  output logic                  bus_err
);

`ifdef BUS_TGT_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam int MEM_WORDS = RANGE_CHK ? DEPTH : (1 << ADDR_WIDTH);

  bus_state_t              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    op_wr;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [WAIT_CNT_W-1:0]   cnt;

  logic                    strobe;
  logic                    wr_now;
  logic                    enter_comp;
  logic                    comp_wr;
  logic [DATA_WIDTH-1:0]   comp_wdata;
  logic                    in_range;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  assign strobe = bus_read_en | bus_write_en;
  // Both strobes high counts as a read.
  assign wr_now = bus_write_en & ~bus_read_en;

  // With zero wait states the access completes straight from ADDR, so the
  // operation and write data come from the live strobe rather than the capture regs.
  assign enter_comp = ((state == ADDR) && !ale_en && strobe && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == WAIT_CNT_W'(1)));
  assign comp_wr    = (state == ADDR) ? wr_now     : op_wr;
  assign comp_wdata = (state == ADDR) ? data_write : wdata_q;

  assign in_range = !RANGE_CHK || (32'(addr_q) < 32'(DEPTH));
  assign mem_we   = enter_comp & comp_wr & in_range;

  bus_tgt_mem #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .WORDS (MEM_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (comp_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      op_wr     <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      data_read <= '0;
      bus_ready <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      bus_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ale_en) begin
            addr_q   <= addr_in;
            state    <= ADDR;
            bus_busy <= 1'b1;
          end else begin
            bus_busy <= 1'b0;
          end
        end
        ADDR: begin
          bus_busy <= 1'b1;
          if (ale_en) begin
            addr_q <= addr_in;
          end else if (strobe) begin
            op_wr   <= wr_now;
            wdata_q <= data_write;
            cnt     <= WAIT_CNT_W'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? COMP : WAIT;
          end
        end
        WAIT: begin
          bus_busy <= 1'b1;
          cnt      <= cnt - 1'b1;
          if (cnt == WAIT_CNT_W'(1)) state <= COMP;
        end
        COMP: begin
          bus_ready <= 1'b1;
          if (ale_en) begin
            addr_q   <= addr_in;
            state    <= ADDR;
            bus_busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
      endcase
      // Reads update data_read on the edge into COMP; writes leave it alone.
      if (enter_comp && !comp_wr) data_read <= in_range ? mem_rdata : '0;
    end
  end

`ifdef BUS_TGT_RANGE_CHK_EN
  logic err_pulse;
  // addr_q still holds the completing transfer's address while in COMP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_pulse <= 1'b0;
    else     err_pulse <= (state == COMP) && !in_range;
  end
  assign bus_err = err_pulse;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem_target.sv
// Testbench for bus_mem_target: instance 0 with WAIT_CYCLES=1, instance 1 with WAIT_CYCLES=0.
// Expected values come from a per-instance memory model and the documented latency rules.
module tb_bus_mem_target;

`ifdef BUS_TGT_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int DEPTH = 192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ale_en [2];
  logic [7:0]  addr_in [2];
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy [2];
  logic        busy [2];
  logic        err [2];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: memory contents, which words are defined, last read value.
  logic [31:0] mdl [2][256];
  bit          known [2][256];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  bus_mem_target #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .ale_en(ale_en[0]), .addr_in(addr_in[0]),
    .bus_read_en(rd_en[0]), .bus_write_en(wr_en[0]), .data_write(wdat[0]),
    .data_read(rdat[0]), .bus_ready(rdy[0]), .bus_busy(busy[0]), .bus_err(err[0]));

  bus_mem_target #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .ale_en(ale_en[1]), .addr_in(addr_in[1]),
    .bus_read_en(rd_en[1]), .bus_write_en(wr_en[1]), .data_write(wdat[1]),
    .data_read(rdat[1]), .bus_ready(rdy[1]), .bus_busy(busy[1]), .bus_err(err[1]));

  function automatic int wc_of(input int s);
    return (s == 0) ? 1 : 0;
  endfunction

  function automatic bit oor(input logic [7:0] a);
    return RC && (int'(a) >= DEPTH);
  endfunction

  // Model update for a completed transfer.
  task automatic model_xfer(input int s, input bit wr, input logic [7:0] a, input logic [31:0] d);
    if (wr) begin
      if (!oor(a)) begin mdl[s][a] = d; known[s][a] = 1'b1; end
    end else begin
      last_rd[s] = oor(a) ? 32'h0 : mdl[s][a];
    end
  endtask

  // One complete transfer; lat counts edges after the strobe edge until bus_ready is seen
  // (-1 on timeout). Noise strobes are driven during WAIT/COMP and must be ignored.
  task automatic xfer(input int s, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e, output logic wide);
    lat = -1; rd = 'x; e = 'x; wide = 1'b0;
    @(negedge clk); ale_en[s] = 1'b1; addr_in[s] = a;
    @(negedge clk); ale_en[s] = 1'b0; addr_in[s] = 8'($urandom);
    wr_en[s] = wr; rd_en[s] = !wr; wdat[s] = wr ? d : $urandom;
    if (!wr && $urandom_range(0, 3) == 0) wr_en[s] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rdy[s]) begin
        lat = n; rd = rdat[s]; e = err[s];
        @(negedge clk); wide = rdy[s];
        break;
      end
      rd_en[s] = 1'($urandom); wr_en[s] = 1'($urandom); wdat[s] = $urandom;
    end
    rd_en[s] = 1'b0; wr_en[s] = 1'b0;
    model_xfer(s, wr, a, d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if ({rdat[s], rdy[s], busy[s], err[s]} !== 35'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got data=%h rdy=%b busy=%b err=%b want all 0",
                 s, rdat[s], rdy[s], busy[s], err[s]);
      end
      last_rd[s] = 32'h0;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] rd; logic e, wide;
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, lat, rd, e, wide);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL basic_wr_lat: got %0d want 2", lat); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_wr_dr: got %h want 0", rd); end
    n_chk++; if (wide !== 1'b0) begin n_fail++; $display("FAIL basic_wr_pulse: ready still %b want 0", wide); end
    xfer(0, 1'b0, 8'h10, 32'h0, lat, rd, e, wide);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL basic_rd_lat: got %0d want 2", lat); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err: got %b want 0", e); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic e, wide;
    xfer(0, 1'b1, 8'h20, 32'h0BADF00D, lat, rd, e, wide);
    @(negedge clk); ale_en[0] = 1'b1; addr_in[0] = 8'h10;
    @(negedge clk); ale_en[0] = 1'b0; rd_en[0] = 1'b1;
    @(negedge clk); rd_en[0] = 1'b0;               // WAIT
    @(negedge clk); ale_en[0] = 1'b1; addr_in[0] = 8'h20; // COMP
    @(negedge clk);
    n_chk++;
    if ({rdy[0], busy[0]} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_no_idle: got rdy=%b busy=%b want 1 1", rdy[0], busy[0]);
    end
    n_chk++; if (rdat[0] !== mdl[0][8'h10]) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", rdat[0], mdl[0][8'h10]); end
    ale_en[0] = 1'b0; rd_en[0] = 1'b1;
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); rd_en[0] = 1'b0;
      if (rdy[0]) begin lat = n; break; end
    end
    model_xfer(0, 1'b0, 8'h20, 32'h0);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_second_lat: got %0d want 2", lat); end
    n_chk++; if (rdat[0] !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_second_data: got %h want 0badf00d", rdat[0]); end
  endtask

  task automatic test_relatch;
    int lat; logic [31:0] rd; logic e, wide;
    xfer(0, 1'b1, 8'h05, 32'h55550005, lat, rd, e, wide);
    xfer(0, 1'b1, 8'h06, 32'h66660006, lat, rd, e, wide);
    @(negedge clk); ale_en[0] = 1'b1; addr_in[0] = 8'h05;
    @(negedge clk); addr_in[0] = 8'h06;
    @(negedge clk); ale_en[0] = 1'b0; rd_en[0] = 1'b1;
    lat = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); rd_en[0] = 1'b0;
      if (rdy[0]) begin lat = n; break; end
    end
    model_xfer(0, 1'b0, 8'h06, 32'h0);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL relatch_lat: got %0d want 2", lat); end
    n_chk++; if (rdat[0] !== 32'h66660006) begin n_fail++; $display("FAIL relatch_data: got %h want 66660006", rdat[0]); end
  endtask

  task automatic test_reset_mid_write;
    int lat, pulses; logic [31:0] rd; logic e, wide;
    xfer(0, 1'b1, 8'h30, 32'hA5A50030, lat, rd, e, wide);
    @(negedge clk); ale_en[0] = 1'b1; addr_in[0] = 8'h30;
    @(negedge clk); ale_en[0] = 1'b0; wr_en[0] = 1'b1; wdat[0] = 32'h12345678;
    @(negedge clk); wr_en[0] = 1'b0; rst = 1'b1;   // in WAIT
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      if (rdy[0]) pulses++;
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses); end
    xfer(0, 1'b0, 8'h30, 32'h0, lat, rd, e, wide);
    n_chk++; if (rd !== 32'hA5A50030) begin n_fail++; $display("FAIL abort_old_value: got %h want a5a50030", rd); end
  endtask

  task automatic test_wait0;
    int lat, bad; logic [31:0] rd; logic e, wide;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); rd_en[1] = 1'($urandom); wr_en[1] = 1'b1; wdat[1] = $urandom;
      if (busy[1] !== 1'b0 || rdy[1] !== 1'b0) bad++;
    end
    @(negedge clk); rd_en[1] = 1'b0; wr_en[1] = 1'b0;
    if (busy[1] !== 1'b0 || rdy[1] !== 1'b0) bad++;
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL idle_strobes: got %0d busy/ready cycles want 0", bad); end
    xfer(1, 1'b1, 8'h44, 32'hC0FFEE44, lat, rd, e, wide);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL wc0_wr_lat: got %0d want 1", lat); end
    xfer(1, 1'b0, 8'h44, 32'h0, lat, rd, e, wide);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL wc0_rd_lat: got %0d want 1", lat); end
    n_chk++; if (rd !== 32'hC0FFEE44) begin n_fail++; $display("FAIL wc0_rd_data: got %h want c0ffee44", rd); end
    n_chk++; if (wide !== 1'b0) begin n_fail++; $display("FAIL wc0_pulse: ready still %b want 0", wide); end
  endtask

`ifdef BUS_TGT_RANGE_CHK_EN
  task automatic test_range;
    int lat, bad; logic [31:0] rd; logic e, wide;
    xfer(0, 1'b0, 8'hC0, 32'h0, lat, rd, e, wide);
    n_chk++; if ({lat == 2, e} !== 2'b11) begin n_fail++; $display("FAIL oor_rd: got lat=%0d err=%b want 2 1", lat, e); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    xfer(0, 1'b1, 8'hFF, 32'hFFFFFFFF, lat, rd, e, wide);
    n_chk++; if ({lat == 2, e} !== 2'b11) begin n_fail++; $display("FAIL oor_wr: got lat=%0d err=%b want 2 1", lat, e); end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (known[0][a]) begin
        xfer(0, 1'b0, 8'(a), 32'h0, lat, rd, e, wide);
        if (rd !== mdl[0][a] || e !== 1'b0) bad++;
      end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL oor_mem_intact: got %0d bad words want 0", bad); end
  endtask
`endif

  task automatic test_random;
    int lat; logic [31:0] rd, exp_rd; logic e, wide; bit wr; logic [7:0] a; logic [31:0] d; int s;
    for (int i = 0; i < 80; i++) begin
      s = $urandom_range(0, 1);
      wr = 1'($urandom); a = 8'($urandom); d = $urandom;
      if (!wr && !oor(a) && !known[s][a]) wr = 1'b1;
      // data_read after a write is the previous read; after a read it is the model word.
      exp_rd = wr ? last_rd[s] : (oor(a) ? 32'h0 : mdl[s][a]);
      xfer(s, wr, a, d, lat, rd, e, wide);
      n_chk++;
      if (lat !== wc_of(s) + 1 || rd !== exp_rd || e !== oor(a) || wide !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d dut%0d %s a=%h: got lat=%0d data=%h err=%b wide=%b want lat=%0d data=%h err=%b wide=0",
                 i, s, wr ? "wr" : "rd", a, lat, rd, e, wide, wc_of(s) + 1, exp_rd, oor(a));
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      ale_en[s] = 1'b0; addr_in[s] = 8'h0; rd_en[s] = 1'b0; wr_en[s] = 1'b0; wdat[s] = 32'h0;
      last_rd[s] = 32'h0;
      for (int a = 0; a < 256; a++) known[s][a] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_relatch();
    test_reset_mid_write();
    test_wait0();
`ifdef BUS_TGT_RANGE_CHK_EN
    test_range();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_mem_target.md
# bus_mem_target

Memory-side responder for the system bus. It latches an address on `ale_en`, accepts one read or write strobe, and inserts a fixed number of wait states. It then services the access against a local word-addressed memory array and signals completion with a one-cycle `bus_ready` pulse. It sits on the slave end of the bus, opposite the bus controller that drives `ale_en` and `bus_read_en`/`bus_write_en`.

## Interface
- `ADDR_WIDTH`, 8, address width in bits; matches the system address bus width
- `DATA_WIDTH`, 32, data word width; matches the memory word width
- `DEPTH`, 192, number of implemented words; used only when the range check is compiled in
- `WAIT_CYCLES`, 1, wait states between accepting the strobe and completion; legal range 0..15
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `ale_en` in 1: address latch enable; `addr_in` is valid while it is high
- `addr_in` in ADDR_WIDTH: word address
- `bus_read_en` in 1: read strobe, sampled in the address phase
- `bus_write_en` in 1: write strobe, sampled in the address phase
- `data_write` in DATA_WIDTH: write data, captured together with `bus_write_en`
- `data_read` out DATA_WIDTH: registered read data
- `bus_ready` out 1: one-cycle completion pulse
- `bus_busy` out 1: high in the ADDR, WAIT and COMP states
- `bus_err` out 1: error flag, pulses together with `bus_ready`; tied to 0 without the macro

## Operation
- The FSM is one-hot with four states: IDLE=4'b0001, ADDR=4'b0010, WAIT=4'b0100, COMP=4'b1000.
- IDLE:
  - `ale_en`=1: latch `addr_in` and go to ADDR.
  - Read and write strobes are ignored.
- ADDR:
  - `ale_en`=1: re-latch the address and stay in ADDR. This takes priority over the strobes.
  - Otherwise, `bus_read_en` or `bus_write_en`: capture the operation and, for a write, `data_write`. Load the wait counter with WAIT_CYCLES. Go to WAIT, or go directly to COMP when WAIT_CYCLES=0.
  - Both strobes high: treat as a read.
  - No strobe: stay in ADDR indefinitely.
- WAIT:
  - The counter decrements every cycle.
  - Leave for COMP on the cycle the counter equals 1.
  - All bus inputs are ignored.
- Transition into COMP (same edge):
  - A write commits the captured data to `mem[addr]`.
  - A read loads `data_read` with `mem[addr]`.
- COMP: `bus_ready`=1 for exactly one cycle.
  - `ale_en`=1: latch the new address and go to ADDR (back-to-back transfers).
  - Otherwise go to IDLE.
- `data_read` holds its value until the next completed read. Writes do not change it.
- Memory contents are not reset.

## Timing
- Reset values: state=IDLE, `data_read`=0, `bus_ready`=0, `bus_busy`=0, `bus_err`=0, wait counter=0.
- Latency: `bus_ready` and valid `data_read` appear WAIT_CYCLES+1 cycles after the edge that sampled the strobe in ADDR.
  - WAIT_CYCLES=0 gives 1 cycle.
  - WAIT_CYCLES=1 gives 2 cycles.
- `bus_busy` goes high the cycle after `ale_en` is sampled in IDLE. It stays high through COMP.
- Reset asserted mid-transfer aborts it immediately:
  - A write whose transition into COMP has not yet occurred is not committed.
  - No `bus_ready` pulse is generated.
- Strobes asserted in IDLE, WAIT or COMP are dropped with no side effect.

## Configuration
- Macro: `BUS_TGT_RANGE_CHK_EN`.
- Defined:
  - The array holds DEPTH words.
  - An access with address ≥ DEPTH follows normal timing, but performs no memory access.
  - Such a read loads `data_read` with 0.
  - `bus_err` pulses high together with `bus_ready`.
- Undefined:
  - The array holds 2^ADDR_WIDTH words and DEPTH is ignored.
  - Every address is valid.
  - `bus_err` is constant 0.

## Structure
- Shared package `bus_pkg` holds:
  - the one-hot state constants IDLE/ADDR/WAIT/COMP;
  - the default address width (8) and data width (32);
  - the wait-counter width (4).
- One sub-module, `bus_tgt_mem`: a synchronous single-port word array.
  - Ports: write enable, address, write data, read data.
  - No reset.
  - Read and write complete on the edge the FSM enters COMP.

## Test plan
- Reset, WAIT_CYCLES=1: write 0xDEADBEEF to address 0x10, then read 0x10.
  - `bus_ready` arrives 2 cycles after each strobe.
  - The read returns 0xDEADBEEF.
  - `data_read` stays 0 through the write.
- Back-to-back: `ale_en` with address 0x20 during COMP of a read from 0x10.
  - The FSM goes COMP→ADDR with no IDLE cycle.
  - A read of 0x20 returns its stored value.
- Address re-latch: `ale_en` with 0x05, then 0x06 while in ADDR, then read.
  - The data returned is `mem[0x06]`.
- Reset mid-write: assert `rst` during WAIT of a write of 0x12345678 to 0x30, then read 0x30.
  - The old value is returned.
  - No `bus_ready` pulse occurs during the aborted transfer.
- With `BUS_TGT_RANGE_CHK_EN` and DEPTH=192: read 0xC0, then write 0xFF.
  - Each produces `bus_ready` together with `bus_err`=1.
  - The read returns `data_read`=0.
  - `mem[0x00..0xBF]` is unchanged.
- WAIT_CYCLES=0: strobe sampled at edge k.
  - `bus_ready` is high in the cycle after edge k+1.
  - Strobes asserted in IDLE are ignored (`bus_busy` stays 0).
